axis_shift_window_buffer: RTL
=============================

Name: axis_shift_window_buffer

Overview:
Multi-copy, runtime-configurable successor to the conv-input shift buffer. It sits between the input pixel reshaper and the conv engine.
Each accepted input beat carries COPIES lanes of CONV_UNITS+KERNEL_H_MAX-1 row pixels. From that beat the block emits kernel_h output beats; each output beat is a CONV_UNITS-row window shifted down by one row from the previous one.
Per-frame config is latched on start. Output sideband (tuser, tlast) is generated from cin and column counters.

Parameters:
DATA_WIDTH, 16, bits per pixel
CONV_UNITS, 8, output rows per lane
COPIES, 2, independent parallel lanes sharing one handshake
KERNEL_H_MAX, 3, max kernel height; input rows = CONV_UNITS+KERNEL_H_MAX-1
KERNEL_W_MAX, 3, max kernel width
CIN_COUNTER_WIDTH, 5, width of cin_1
COLS_COUNTER_WIDTH, 10, width of cols_1
TUSER_WIDTH, 4, sideband width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latches config when IDLE
kernel_h_1_in  in  clog2(KERNEL_H_MAX+1)  kernel height-1 (0..KERNEL_H_MAX-1)
kernel_w_1_in  in  clog2(KERNEL_W_MAX+1)  kernel width-1
is_max, is_relu  in  1 each  mode flags
cols_1  in  COLS_COUNTER_WIDTH  columns-1
cin_1  in  CIN_COUNTER_WIDTH  input channels-1
S_AXIS_tdata  in  COPIES*(CONV_UNITS+KERNEL_H_MAX-1)*DATA_WIDTH  lane-major, row 0 at LSB
S_AXIS_tvalid  in  1
S_AXIS_tready  out  1
M_AXIS_tdata  out  COPIES*CONV_UNITS*DATA_WIDTH  same packing
M_AXIS_tvalid  out  1
M_AXIS_tready  in  1
M_AXIS_tlast  out  1  last beat of frame
M_AXIS_tuser  out  TUSER_WIDTH  flags
kernel_h_1_out, kernel_w_1_out  out  as inputs  latched config
busy  out  1  high from start until tlast handshake

Behaviour:
- Reset (async, aresetn=0): every output is 0, state IDLE, all counters 0, buffer cleared.
- IDLE:
  - S_AXIS_tready=0.
  - On start=1: latch all config, go RUN, busy=1 on the next cycle.
  - start in RUN is ignored.
- RUN:
  - Buffer holds one input beat plus a valid flag.
  - S_AXIS_tready = !M_AXIS_tvalid || (M_AXIS_tready && kh_cnt==kh_1 && !last_beat).
  - This gives zero-bubble back-to-back beats: one input per kernel_h outputs.
- Input accept: buffer <= tdata, kh_cnt <= 0, M_AXIS_tvalid <= 1 on the next cycle (latency 1).
- Output window:
  - lane c, row i = buffer[c][i+kh_cnt].
  - Implemented as a one-row down-shift of every lane on each output handshake with kh_cnt<kh_1. No wide mux.
- Output handshake:
  - If kh_cnt<kh_1: kh_cnt++.
  - Else the beat is done. Advance cin_cnt; on cin_cnt==cin_1, wrap to 0 and advance col_cnt.
  - M_AXIS_tvalid drops unless a new beat is accepted in the same cycle.
- Backpressure: while M_AXIS_tready=0, tdata, tuser and tlast are held stable.
- tuser bits, as indices in the package:
  - IS_1x1 = (kh_1==0 && kw_1==0).
  - IS_MAX = is_max.
  - IS_RELU = is_relu.
  - IS_COLS_1_K2 = (col_cnt == cols_1 - (kw_1>>1)); compare at COLS_COUNTER_WIDTH, with the subtraction saturating at 0.
- tlast = (col_cnt==cols_1 && cin_cnt==cin_1 && kh_cnt==kh_1).
  - On its handshake: return to IDLE, busy=0, counters cleared.
  - Input beats arriving after that are not accepted.
- kernel_h_1_in > KERNEL_H_MAX-1: clamped to KERNEL_H_MAX-1.
- Reset mid-frame: immediate abort; the next frame needs a new start.

Decomposition:
- Package axis_shift_window_pkg:
  - tuser index constants INDEX_IS_1x1=0, INDEX_IS_MAX=1, INDEX_IS_RELU=2, INDEX_IS_COLS_1_K2=3.
  - Width localparams KERNEL_H_WIDTH and KERNEL_W_WIDTH.
  - State enum {IDLE, RUN}.
- One sub-module, shift_window_lane: a per-lane load/shift register, generated COPIES times. Control and counters stay in the top module.

Test Plan:
- Config kh_1=2, kw_1=2, cin_1=5, cols_1=9; lane0 row m = m*100+k (k = beat index), lane1 = lane0+50000; M_AXIS_tready=1 throughout.
  - Expect 60 inputs and 180 outputs.
  - Output j of beat k has row i = (i+j)*100+k.
  - tlast only on output 180.
  - IS_COLS_1_K2 on columns 8 only.
- 1x1 config (kh_1=0, kw_1=0):
  - One output per input.
  - S_AXIS_tready stays high through the frame at full rate.
  - IS_1x1 set on every beat.
- M_AXIS_tready low for cycles 25-28, then S_AXIS_tvalid low for cycles 31-39:
  - Output held stable while stalled.
  - No beat duplicated or lost.
  - Output count still 180.
- start pulsed mid-frame with a different cin_1:
  - Ignored; frame completes with the original counts.
  - busy falls only after the tlast handshake.
- aresetn asserted after 40 outputs:
  - All outputs 0 within the same cycle.
  - After release plus a new start, the full 180-beat frame is correct.

Source files
------------

// File: rtl/axis_shift_window_pkg.sv
// Shared constants and types for the multi-copy conv-input shift window buffer.
package axis_shift_window_pkg;

  // Default geometry; the top module exposes these as overridable parameters.
  localparam int DEF_DATA_WIDTH         = 16;
  localparam int DEF_CONV_UNITS         = 8;
  localparam int DEF_COPIES             = 2;
  localparam int DEF_KERNEL_H_MAX       = 3;
  localparam int DEF_KERNEL_W_MAX       = 3;
  localparam int DEF_CIN_COUNTER_WIDTH  = 5;
  localparam int DEF_COLS_COUNTER_WIDTH = 10;
  localparam int DEF_TUSER_WIDTH        = 4;

  localparam int KERNEL_H_WIDTH = $clog2(DEF_KERNEL_H_MAX + 1);
  localparam int KERNEL_W_WIDTH = $clog2(DEF_KERNEL_W_MAX + 1);

  // Bit positions inside M_AXIS tuser.
  localparam int INDEX_IS_1x1       = 0;
  localparam int INDEX_IS_MAX       = 1;
  localparam int INDEX_IS_RELU      = 2;
  localparam int INDEX_IS_COLS_1_K2 = 3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

endpackage

// File: rtl/axis_shift_window_buffer_if.sv
// AXI-stream bundle used on both sides of the shift window buffer.
interface axis_shift_window_if
  import axis_shift_window_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH
);
  logic [DATA_WIDTH-1:0]  tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  // Producer side drives payload + sideband.
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  // The input side of this block carries no sideband.
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_shift_window_buffer_lane.sv
// One lane of the window buffer: loads a full column of input rows, then
// shifts down one row per emitted window so the output taps never move.
module shift_window_lane
  import axis_shift_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_ROWS    = DEF_CONV_UNITS + DEF_KERNEL_H_MAX - 1,
  parameter int OUT_ROWS   = DEF_CONV_UNITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic                           i_shift,
  input  logic [IN_ROWS*DATA_WIDTH-1:0]  i_data,
  output logic [OUT_ROWS*DATA_WIDTH-1:0] o_window
);
  logic [IN_ROWS-1:0][DATA_WIDTH-1:0] r_rows;

  // Load wins; a shift moves every row one slot toward row 0, zero-filling the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rows <= '0;
    else if (i_load)  r_rows <= i_data;
    else if (i_shift) r_rows <= r_rows >> DATA_WIDTH;
  end

  assign o_window = r_rows[OUT_ROWS-1:0];
endmodule

// File: rtl/axis_shift_window_buffer.sv
// Conv-input shift window buffer: each accepted input beat produces kernel_h
// output windows, each one row further down, with tuser/tlast derived from
// the cin/column position inside the frame.
module axis_shift_window_buffer
  import axis_shift_window_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int CONV_UNITS         = DEF_CONV_UNITS,
  parameter int COPIES             = DEF_COPIES,
  parameter int KERNEL_H_MAX       = DEF_KERNEL_H_MAX,
  parameter int KERNEL_W_MAX       = DEF_KERNEL_W_MAX,
  parameter int CIN_COUNTER_WIDTH  = DEF_CIN_COUNTER_WIDTH,
  parameter int COLS_COUNTER_WIDTH = DEF_COLS_COUNTER_WIDTH,
  parameter int TUSER_WIDTH        = DEF_TUSER_WIDTH
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   start,
  input  logic [$clog2(KERNEL_H_MAX+1)-1:0]      kernel_h_1_in,
  input  logic [$clog2(KERNEL_W_MAX+1)-1:0]      kernel_w_1_in,
  input  logic                                   is_max,
  input  logic                                   is_relu,
  input  logic [COLS_COUNTER_WIDTH-1:0]          cols_1,
  input  logic [CIN_COUNTER_WIDTH-1:0]           cin_1,
  axis_shift_window_if.slave                     S_AXIS,
  axis_shift_window_if.master                    M_AXIS,
  output logic [$clog2(KERNEL_H_MAX+1)-1:0]      kernel_h_1_out,
  output logic [$clog2(KERNEL_W_MAX+1)-1:0]      kernel_w_1_out,
  output logic                                   busy
);
  localparam int IN_ROWS = CONV_UNITS + KERNEL_H_MAX - 1;
  localparam int KHW     = $clog2(KERNEL_H_MAX + 1);
  localparam int KWW     = $clog2(KERNEL_W_MAX + 1);
  localparam int COLW    = COLS_COUNTER_WIDTH;
  localparam int CINW    = CIN_COUNTER_WIDTH;
  localparam logic [KHW-1:0] KH_1_MAX = KHW'(KERNEL_H_MAX - 1);

  state_t          r_state;
  logic [KHW-1:0]  r_kh_1, r_kh_cnt;
  logic [KWW-1:0]  r_kw_1;
  logic            r_is_max, r_is_relu;
  logic [COLW-1:0] r_cols_1, r_col_cnt;
  logic [CINW-1:0] r_cin_1, r_cin_cnt;
  logic            r_mvalid, r_busy;

  logic            w_kh_done, w_last_beat, w_s_ready, w_in_hs, w_out_hs, w_shift;
  logic [KHW-1:0]  w_kh_clamped;
  logic [COLW-1:0] w_kw_half, w_col_tgt;
  logic [TUSER_WIDTH-1:0] w_user;
  logic [COPIES*CONV_UNITS*DATA_WIDTH-1:0] w_mdata;

  assign w_kh_clamped = (kernel_h_1_in > KH_1_MAX) ? KH_1_MAX : kernel_h_1_in;
  assign w_kh_done    = (r_kh_cnt == r_kh_1);
  assign w_last_beat  = (r_col_cnt == r_cols_1) && (r_cin_cnt == r_cin_1) && w_kh_done;
  // Take a new beat when empty, or when the last window of the current beat
  // leaves this cycle and it is not the frame's final window.
  assign w_s_ready    = (r_state == RUN) &&
                        (!r_mvalid || (M_AXIS.tready && w_kh_done && !w_last_beat));
  assign w_in_hs      = S_AXIS.tvalid && w_s_ready;
  assign w_out_hs     = r_mvalid && M_AXIS.tready;
  assign w_shift      = w_out_hs && !w_kh_done;

  // Column flagged for the right-edge kernel overhang, saturating at column 0.
  assign w_kw_half = COLW'(r_kw_1 >> 1);
  assign w_col_tgt = (r_cols_1 >= w_kw_half) ? (r_cols_1 - w_kw_half) : '0;

  // Control FSM: config latch on start, kh/cin/col position tracking, output valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_kh_1    <= '0;
      r_kw_1    <= '0;
      r_is_max  <= 1'b0;
      r_is_relu <= 1'b0;
      r_cols_1  <= '0;
      r_cin_1   <= '0;
      r_kh_cnt  <= '0;
      r_cin_cnt <= '0;
      r_col_cnt <= '0;
      r_mvalid  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kh_1    <= w_kh_clamped;
            r_kw_1    <= kernel_w_1_in;
            r_is_max  <= is_max;
            r_is_relu <= is_relu;
            r_cols_1  <= cols_1;
            r_cin_1   <= cin_1;
            r_kh_cnt  <= '0;
            r_cin_cnt <= '0;
            r_col_cnt <= '0;
            r_mvalid  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_out_hs) begin
            if (!w_kh_done) begin
              r_kh_cnt <= r_kh_cnt + 1'b1;
            end else if (w_last_beat) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_kh_cnt  <= '0;
              r_cin_cnt <= '0;
              r_col_cnt <= '0;
            end else if (r_cin_cnt == r_cin_1) begin
              r_cin_cnt <= '0;
              r_col_cnt <= r_col_cnt + 1'b1;
            end else begin
              r_cin_cnt <= r_cin_cnt + 1'b1;
            end
          end
          if (w_in_hs) begin
            r_kh_cnt <= '0;
            r_mvalid <= 1'b1;
          end else if (w_out_hs && w_kh_done) begin
            r_mvalid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sideband is only meaningful alongside a valid window; zero otherwise.
  always_comb begin
    w_user = '0;
    if (r_mvalid) begin
      w_user[INDEX_IS_1x1]       = (r_kh_1 == '0) && (r_kw_1 == '0);
      w_user[INDEX_IS_MAX]       = r_is_max;
      w_user[INDEX_IS_RELU]      = r_is_relu;
      w_user[INDEX_IS_COLS_1_K2] = (r_col_cnt == w_col_tgt);
    end
  end

  for (genvar c = 0; c < COPIES; c++) begin : g_lane
    shift_window_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IN_ROWS    (IN_ROWS),
      .OUT_ROWS   (CONV_UNITS)
    ) u_lane (
      .clk      (aclk),
      .rst_n    (aresetn),
      .i_load   (w_in_hs),
      .i_shift  (w_shift),
      .i_data   (S_AXIS.tdata[c*IN_ROWS*DATA_WIDTH +: IN_ROWS*DATA_WIDTH]),
      .o_window (w_mdata[c*CONV_UNITS*DATA_WIDTH +: CONV_UNITS*DATA_WIDTH])
    );
  end

  assign S_AXIS.tready  = w_s_ready;
  assign M_AXIS.tdata   = w_mdata;
  assign M_AXIS.tvalid  = r_mvalid;
  assign M_AXIS.tlast   = r_mvalid && w_last_beat;
  assign M_AXIS.tuser   = w_user;
  assign kernel_h_1_out = r_kh_1;
  assign kernel_w_1_out = r_kw_1;
  assign busy           = r_busy;
endmodule
